// File: rtl/i2c_pkg.sv
// Shared types for the I2C init sequencer: FSM encoding, default slave address,
// table-entry layout and the counter width helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_READY = 3'd2,
    ST_ISSUE      = 3'd3,
    ST_WAIT_DONE  = 3'd4,
    ST_GAP        = 3'd5,
    ST_FINISH     = 3'd6,
    ST_FAIL       = 3'd7
  } state_t;

  localparam logic [6:0] I2C_DEV_ADDR = 7'h68;

  typedef struct packed {
    logic [7:0] sub;
    logic [7:0] data;
  } entry_t;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// i2c_init_rom: register-write table, index -> {sub, data}.
// Latency: combinational. Backpressure: none; unused indices read as zero.
// Entry order is the power-up order expected by the slave.
module i2c_init_rom
  import i2c_pkg::*;
(
  input  logic [3:0]  index,
  output logic [15:0] entry_dat
);

  entry_t entry;

  always_comb begin
    entry = '0;
    case (index)
      4'd0:    entry = '{sub: 8'h20, data: 8'h0F};
      4'd1:    entry = '{sub: 8'h23, data: 8'h30};
      4'd2:    entry = '{sub: 8'h22, data: 8'h08};
      4'd3:    entry = '{sub: 8'h21, data: 8'h00};
      default: entry = '0;
    endcase
  end

  assign entry_dat = entry;

endmodule

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks the init table through the I2C master, one write per entry.
// Latency: go to first m_start is 3 cycles with m_ready high; transfers spaced by GAP_CYCLES.
// Backpressure: waits on m_ready/m_done, each bounded by TIMEOUT; I2C_SEQ_RETRY_EN adds per-entry retries.
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_WRITES = 4,
  parameter logic [6:0]  DEV_ADDR   = I2C_DEV_ADDR,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  output logic       busy,
  output logic       seq_done,
  output logic       error,
  output logic [3:0] err_index,
  output logic [3:0] cur_index,
  output logic       m_start,
  output logic [6:0] m_addr,
  output logic [7:0] m_sub,
  output logic [7:0] m_data,
  input  logic       m_ready,
  input  logic       m_done
`ifdef I2C_SEQ_RETRY_EN
  ,
  output logic [1:0] retry_cnt
`endif
);

`ifdef I2C_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int unsigned CW       = cnt_width(TIMEOUT, GAP_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  // A wait is abandoned exactly TIMEOUT cycles after the state that cleared the counter.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX = 4'(NUM_WRITES - 1);

  state_t        state;
  state_t        next_state;
  entry_t        rom_entry;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] gap_cnt;
  logic [1:0]    retry_q;
  logic          m_done_q;
  logic          done_rise;
  logic          tmo_hit;
  logic          tmo_take;
  logic          gap_end;
  logic          last_entry;
  logic          can_retry;
  logic          retry_pend;

  i2c_init_rom u_rom (
    .index     (cur_index),
    .entry_dat (rom_entry)
  );

  assign done_rise  = m_done & ~m_done_q;
  assign tmo_hit    = (tmo_cnt >= TMO_LAST);
  assign gap_end    = (gap_cnt >= GAP_LAST);
  assign last_entry = (cur_index == LAST_IDX);
  assign can_retry  = RETRY_EN && (32'(retry_q) < MAX_RETRY);
  assign retry_pend = RETRY_EN && (retry_q != 2'd0);
  // Progress wins over a timeout landing in the same cycle.
  assign tmo_take   = tmo_hit && (((state == ST_WAIT_READY) && !m_ready) ||
                                  ((state == ST_WAIT_DONE) && !done_rise));

`ifdef I2C_SEQ_RETRY_EN
  assign retry_cnt = retry_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:       if (go) next_state = ST_LOAD;
      ST_LOAD:       next_state = ST_WAIT_READY;
      ST_WAIT_READY: begin
        if (m_ready)       next_state = ST_ISSUE;
        else if (tmo_take) next_state = can_retry ? ST_GAP : ST_FAIL;
      end
      ST_ISSUE:      next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done_rise)     next_state = ST_GAP;
        else if (tmo_take) next_state = can_retry ? ST_GAP : ST_FAIL;
      end
      // A pending retry reloads the same entry instead of advancing.
      ST_GAP:        if (gap_end) next_state = (retry_pend || !last_entry) ? ST_LOAD : ST_FINISH;
      ST_FINISH:     next_state = ST_IDLE;
      ST_FAIL:       next_state = ST_IDLE;
      default:       next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    seq_done = 1'b0;
    m_start  = 1'b0;
    m_addr   = DEV_ADDR;
    case (state)
      ST_LOAD, ST_WAIT_READY, ST_WAIT_DONE, ST_GAP: busy = 1'b1;
      ST_ISSUE: begin
        busy    = 1'b1;
        m_start = 1'b1;
      end
      ST_FINISH: seq_done = 1'b1;
      default:   busy     = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_sub     <= '0;
      m_data    <= '0;
      cur_index <= '0;
      error     <= 1'b0;
      err_index <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      retry_q   <= '0;
      m_done_q  <= 1'b0;
    end else begin
      m_done_q <= m_done;

      if (state == ST_LOAD) begin
        m_sub  <= rom_entry.sub;
        m_data <= rom_entry.data;
      end

      if ((state == ST_LOAD) || (state == ST_ISSUE))
        tmo_cnt <= '0;
      else if (((state == ST_WAIT_READY) || (state == ST_WAIT_DONE)) && (tmo_cnt != CNT_MAX))
        tmo_cnt <= tmo_cnt + CW'(1);

      if (state != ST_GAP)         gap_cnt <= '0;
      else if (gap_cnt != CNT_MAX) gap_cnt <= gap_cnt + CW'(1);

      if ((state == ST_IDLE) && go) begin
        cur_index <= '0;
        error     <= 1'b0;
        retry_q   <= '0;
      end else if ((state == ST_GAP) && gap_end && !retry_pend && !last_entry) begin
        cur_index <= cur_index + 4'd1;
      end

      if (next_state == ST_FAIL) begin
        error     <= 1'b1;
        err_index <= cur_index;
      end

      if ((state == ST_WAIT_DONE) && done_rise) retry_q <= '0;
      else if (tmo_take && can_retry)           retry_q <= retry_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer with a simple master model (done 20 cycles after start).
// Retry scenario replaces the hard-timeout scenario when I2C_SEQ_RETRY_EN is defined.
module tb_i2c_init_sequencer;

  localparam int TMO = 200;
  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic       m_ready = 1'b0;
  logic       m_done = 1'b0;
  logic       busy, seq_done, error, m_start;
  logic [3:0] err_index, cur_index;
  logic [6:0] m_addr;
  logic [7:0] m_sub, m_data;
`ifdef I2C_SEQ_RETRY_EN
  logic [1:0] retry_cnt;
  logic [1:0] st_rcnt [64];
`endif

  int total = 0, bad = 0, cyc = 0;
  int st_cyc [64];
  int st_gap [64];
  logic [7:0] st_sub [64], st_dat [64];
  logic [6:0] st_addr [64];
  int start_cnt = 0, done_cnt = 0, done_cyc = -1, ready_viol = 0, wide_start = 0;
  logic prev_start = 1'b0;
  int done_at = -1, last_done_cyc = -1000, drop_idx = 0, drop_total = 0, drop_used = 0;

  logic [7:0] exp_sub [4] = '{8'h20, 8'h23, 8'h22, 8'h21};
  logic [7:0] exp_dat [4] = '{8'h0F, 8'h30, 8'h08, 8'h00};

  i2c_init_sequencer #(.TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .busy(busy), .seq_done(seq_done),
    .error(error), .err_index(err_index), .cur_index(cur_index), .m_start(m_start),
    .m_addr(m_addr), .m_sub(m_sub), .m_data(m_data), .m_ready(m_ready), .m_done(m_done)
`ifdef I2C_SEQ_RETRY_EN
    , .retry_cnt(retry_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Start/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_start) begin
      if (!m_ready) ready_viol <= ready_viol + 1;
      if (prev_start) wide_start <= wide_start + 1;
      if (start_cnt < 64) begin
        st_cyc[start_cnt]  <= cyc;
        st_sub[start_cnt]  <= m_sub;
        st_dat[start_cnt]  <= m_data;
        st_addr[start_cnt] <= m_addr;
        st_gap[start_cnt]  <= cyc - last_done_cyc - 1;
`ifdef I2C_SEQ_RETRY_EN
        st_rcnt[start_cnt] <= retry_cnt;
`endif
      end
      start_cnt <= start_cnt + 1;
    end
    prev_start <= m_start;
    if (seq_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // Master model: m_done high for 2 cycles starting 20 cycles after m_start, unless dropped.
  always @(negedge clk) begin
    if (m_start) begin
      if (drop_used < drop_total && int'(cur_index) == drop_idx) drop_used <= drop_used + 1;
      else done_at <= cyc + 20;
    end
    if (cyc == done_at) begin
      m_done <= 1'b1;
      last_done_cyc <= cyc;
    end else if (cyc == done_at + 2) begin
      m_done <= 1'b0;
    end
  end

  task automatic pulse_go(output int g);
    @(posedge clk); #1;
    go = 1'b1;
    g = cyc;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; go = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (seq_done !== 1'b0) begin bad++; $display("FAIL reset_seq_done got=%0b want=0", seq_done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0b want=0", error); end
    total++; if (err_index !== 4'd0) begin bad++; $display("FAIL reset_err_index got=%0d want=0", err_index); end
    total++; if (cur_index !== 4'd0) begin bad++; $display("FAIL reset_cur_index got=%0d want=0", cur_index); end
    total++; if (m_start !== 1'b0) begin bad++; $display("FAIL reset_m_start got=%0b want=0", m_start); end
    total++; if (m_addr !== 7'h68) begin bad++; $display("FAIL reset_m_addr got=%h want=68", m_addr); end
    total++; if (m_sub !== 8'h00) begin bad++; $display("FAIL reset_m_sub got=%h want=00", m_sub); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%h want=00", m_data); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_go_busy got=%0b want=0", busy); end
  endtask

  task automatic test_normal();
    int s0, d0, rv0, w0, g, n;
    s0 = start_cnt; d0 = done_cnt; rv0 = ready_viol; w0 = wide_start;
    m_ready = 1'b1;
    pulse_go(g);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL normal_busy_after_go got=%0b want=1", busy); end
    n = 0;
    while (done_cnt == d0 && error !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    total++; if (n >= 3000) begin bad++; $display("FAIL normal_wait got=timeout want=seq_done"); end
    repeat (3) @(negedge clk);
    total++; if (start_cnt - s0 !== 4) begin bad++; $display("FAIL normal_starts got=%0d want=4", start_cnt - s0); end
    total++; if (st_cyc[s0] !== g + 3) begin bad++; $display("FAIL normal_latency got=%0d want=%0d", st_cyc[s0] - g, 3); end
    for (int i = 0; i < 4; i++) begin
      total++; if (st_sub[s0+i] !== exp_sub[i]) begin bad++; $display("FAIL normal_sub%0d got=%h want=%h", i, st_sub[s0+i], exp_sub[i]); end
      total++; if (st_dat[s0+i] !== exp_dat[i]) begin bad++; $display("FAIL normal_data%0d got=%h want=%h", i, st_dat[s0+i], exp_dat[i]); end
      total++; if (st_addr[s0+i] !== 7'h68) begin bad++; $display("FAIL normal_addr%0d got=%h want=68", i, st_addr[s0+i]); end
    end
    for (int i = 1; i < 4; i++) begin
      total++; if (st_gap[s0+i] < GAP) begin bad++; $display("FAIL normal_gap%0d got=%0d want>=%0d", i, st_gap[s0+i], GAP); end
      total++; if (st_cyc[s0+i] - st_cyc[s0+i-1] !== 39) begin bad++; $display("FAIL normal_spacing%0d got=%0d want=39", i, st_cyc[s0+i] - st_cyc[s0+i-1]); end
    end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL normal_done_cnt got=%0d want=1", done_cnt - d0); end
    total++; if (done_cyc !== st_cyc[s0+3] + 37) begin bad++; $display("FAIL normal_done_time got=%0d want=%0d", done_cyc, st_cyc[s0+3] + 37); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL normal_error got=%0b want=0", error); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL normal_busy_end got=%0b want=0", busy); end
    total++; if (wide_start !== w0) begin bad++; $display("FAIL normal_start_width got=%0d want=%0d", wide_start, w0); end
    total++; if (ready_viol !== rv0) begin bad++; $display("FAIL normal_ready_viol got=%0d want=%0d", ready_viol, rv0); end
  endtask

  task automatic test_duplicate_go();
    int s0, d0, g, g2, n;
    s0 = start_cnt; d0 = done_cnt;
    m_ready = 1'b1;
    pulse_go(g);
    n = 0;
    while (cur_index !== 4'd2 && n < 500) begin @(negedge clk); n++; end
    total++; if (n >= 500) begin bad++; $display("FAIL dup_reach_entry2 got=timeout want=cur_index2"); end
    pulse_go(g2);
    n = 0;
    while (done_cnt == d0 && error !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    total++; if (start_cnt - s0 !== 4) begin bad++; $display("FAIL dup_starts got=%0d want=4", start_cnt - s0); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL dup_done_cnt got=%0d want=1", done_cnt - d0); end
    total++; if (st_sub[s0+2] !== 8'h22) begin bad++; $display("FAIL dup_sub2 got=%h want=22", st_sub[s0+2]); end
    total++; if (st_sub[s0+3] !== 8'h21) begin bad++; $display("FAIL dup_sub3 got=%h want=21", st_sub[s0+3]); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL dup_error got=%0b want=0", error); end
  endtask

  task automatic test_ready_backpressure();
    int s0, d0, rv0, g, r, n;
    s0 = start_cnt; d0 = done_cnt; rv0 = ready_viol;
    m_ready = 1'b0;
    pulse_go(g);
    repeat (100) @(posedge clk);
    #1;
    total++; if (start_cnt !== s0) begin bad++; $display("FAIL bp_no_start got=%0d want=%0d", start_cnt, s0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%0b want=1", busy); end
    m_ready = 1'b1;
    r = cyc;
    n = 0;
    while (done_cnt == d0 && error !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    total++; if (st_cyc[s0] !== r + 1) begin bad++; $display("FAIL bp_first_start got=%0d want=%0d", st_cyc[s0], r + 1); end
    total++; if (ready_viol !== rv0) begin bad++; $display("FAIL bp_ready_viol got=%0d want=%0d", ready_viol, rv0); end
    total++; if (start_cnt - s0 !== 4) begin bad++; $display("FAIL bp_starts got=%0d want=4", start_cnt - s0); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL bp_done_cnt got=%0d want=1", done_cnt - d0); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL bp_error got=%0b want=0", error); end
  endtask

`ifndef I2C_SEQ_RETRY_EN
  task automatic test_timeout();
    int s0, d0, g, n, ec;
    s0 = start_cnt; d0 = done_cnt;
    m_ready = 1'b1;
    drop_idx = 1;
    drop_total = drop_total + 1;
    pulse_go(g);
    n = 0;
    while (error !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    ec = cyc;
    total++; if (n >= 1000) begin bad++; $display("FAIL tmo_wait got=timeout want=error"); end
    total++; if (ec !== st_cyc[s0+1] + TMO) begin bad++; $display("FAIL tmo_time got=%0d want=%0d", ec, st_cyc[s0+1] + TMO); end
    total++; if (err_index !== 4'd1) begin bad++; $display("FAIL tmo_err_index got=%0d want=1", err_index); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%0b want=0", busy); end
    repeat (5) @(negedge clk);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%0b want=1", error); end
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL tmo_no_done got=%0d want=%0d", done_cnt, d0); end
    total++; if (start_cnt - s0 !== 2) begin bad++; $display("FAIL tmo_starts got=%0d want=2", start_cnt - s0); end
    pulse_go(g);
    @(negedge clk);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL tmo_go_clears got=%0b want=0", error); end
    n = 0;
    while (done_cnt == d0 && error !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL tmo_rerun_done got=%0d want=1", done_cnt - d0); end
    total++; if (start_cnt - s0 !== 6) begin bad++; $display("FAIL tmo_rerun_starts got=%0d want=6", start_cnt - s0); end
  endtask
`else
  task automatic test_retry();
    int s0, d0, g, n;
    logic [7:0] exp_rs [5];
    exp_rs = '{8'h20, 8'h23, 8'h23, 8'h22, 8'h21};
    s0 = start_cnt; d0 = done_cnt;
    m_ready = 1'b1;
    drop_idx = 1;
    drop_total = drop_total + 1;
    pulse_go(g);
    n = 0;
    while (done_cnt == d0 && error !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    total++; if (start_cnt - s0 !== 5) begin bad++; $display("FAIL retry_starts got=%0d want=5", start_cnt - s0); end
    for (int i = 0; i < 5; i++) begin
      total++; if (st_sub[s0+i] !== exp_rs[i]) begin bad++; $display("FAIL retry_sub%0d got=%h want=%h", i, st_sub[s0+i], exp_rs[i]); end
    end
    total++; if (st_cyc[s0+2] !== st_cyc[s0+1] + TMO + 18) begin bad++; $display("FAIL retry_time got=%0d want=%0d", st_cyc[s0+2], st_cyc[s0+1] + TMO + 18); end
    total++; if (st_rcnt[s0+1] !== 2'd0) begin bad++; $display("FAIL retry_cnt_first got=%0d want=0", st_rcnt[s0+1]); end
    total++; if (st_rcnt[s0+2] !== 2'd1) begin bad++; $display("FAIL retry_cnt_during got=%0d want=1", st_rcnt[s0+2]); end
    total++; if (retry_cnt !== 2'd0) begin bad++; $display("FAIL retry_cnt_after got=%0d want=0", retry_cnt); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL retry_error got=%0b want=0", error); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL retry_done got=%0d want=1", done_cnt - d0); end
  endtask
`endif

  task automatic test_reset_mid();
    int s0, s1, d0, g, n;
    s0 = start_cnt; d0 = done_cnt;
    m_ready = 1'b1;
    pulse_go(g);
    n = 0;
    while (start_cnt < s0 + 3 && n < 1000) begin @(negedge clk); n++; end
    total++; if (n >= 1000) begin bad++; $display("FAIL rmid_reach_entry2 got=timeout want=start"); end
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", busy); end
    total++; if (cur_index !== 4'd0) begin bad++; $display("FAIL rmid_cur_index got=%0d want=0", cur_index); end
    total++; if (m_sub !== 8'h00) begin bad++; $display("FAIL rmid_m_sub got=%h want=00", m_sub); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL rmid_m_data got=%h want=00", m_data); end
    total++; if (m_start !== 1'b0) begin bad++; $display("FAIL rmid_m_start got=%0b want=0", m_start); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rmid_error got=%0b want=0", error); end
    s1 = start_cnt;
    repeat (60) @(negedge clk);
    total++; if (start_cnt !== s1) begin bad++; $display("FAIL rmid_no_start got=%0d want=%0d", start_cnt, s1); end
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL rmid_no_done got=%0d want=%0d", done_cnt, d0); end
    pulse_go(g);
    n = 0;
    while (done_cnt == d0 && error !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    total++; if (st_sub[s1] !== 8'h20) begin bad++; $display("FAIL rmid_restart_sub got=%h want=20", st_sub[s1]); end
    total++; if (start_cnt - s1 !== 4) begin bad++; $display("FAIL rmid_restart_starts got=%0d want=4", start_cnt - s1); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rmid_restart_done got=%0d want=1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_duplicate_go();
    test_ready_backpressure();
`ifdef I2C_SEQ_RETRY_EN
    test_retry();
`else
    test_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Controller that drives the existing I2C master through a fixed table of register writes to one slave device, e.g. sensor power-up configuration.
- Sits between board-level control (button or power-on pulse) and the I2C master: sequences start/addr/sub/data, waits for completion, spaces transfers and flags failures.
- Runs on the same clock as the I2C master (the divided I2C clock).

Parameters:
- NUM_WRITES, 4, number of table entries issued per sequence (1..16).
- DEV_ADDR, 7'h68, 7-bit slave address driven on m_addr for every entry.
- TIMEOUT, 4096, max cycles spent in WAIT_READY or WAIT_DONE before the entry is declared failed.
- GAP_CYCLES, 16, idle cycles between the end of one transfer and the next start (min 1).
- MAX_RETRY, 3, retries per entry; used only when the optional feature is compiled in.

Ports:
- clk, in, 1, block clock (I2C clock domain).
- reset_n, in, 1, synchronous active-low reset.
- go, in, 1, sequence request; level or pulse, acted on only in IDLE.
- busy, out, 1, high from the cycle after go is accepted until FINISH/FAIL completes.
- seq_done, out, 1, one-cycle pulse when all entries are written successfully.
- error, out, 1, sticky failure flag; cleared on reset or on the next accepted go.
- err_index, out, 4, index of the failing entry; valid while error=1.
- cur_index, out, 4, entry currently being processed.
- m_start, out, 1, start strobe to the I2C master.
- m_addr, out, 7, slave address to the master.
- m_sub, out, 8, register sub-address to the master.
- m_data, out, 8, write data to the master.
- m_ready, in, 1, master idle and able to accept start.
- m_done, in, 1, master completion level; its rising edge marks the end of a transfer.

Behaviour:
- Reset is synchronous and active-low: every state change, including reset, occurs on the rising edge of clk, and reset_n is sampled only on that edge.
- Reset values: state=IDLE; busy=0; seq_done=0; error=0; err_index=0; cur_index=0; m_start=0; m_addr=DEV_ADDR; m_sub=0; m_data=0; timeout counter=0; gap counter=0; retry counter=0; m_done edge register=0.
- States: IDLE, LOAD, WAIT_READY, ISSUE, WAIT_DONE, GAP, FINISH, FAIL.
- IDLE: when go=1, clear error, set cur_index=0 and go to LOAD. go in any other state is ignored.
- LOAD: register {m_sub, m_data} from the ROM at cur_index, clear the timeout counter, go to WAIT_READY.
- WAIT_READY: when m_ready=1, go to ISSUE. If TIMEOUT cycles elapse first, go to FAIL.
- ISSUE: m_start=1 for exactly one cycle. Clear the timeout counter. Go to WAIT_DONE.
- m_sub, m_data and m_addr are held stable from LOAD through WAIT_DONE.
- WAIT_DONE: on an m_done rising edge (m_done=1 and registered previous m_done=0), go to GAP. If the timeout counter reaches TIMEOUT, go to FAIL. A rising edge and the timeout in the same cycle count as success.
- GAP: count GAP_CYCLES cycles.
  - If cur_index == NUM_WRITES-1, go to FINISH.
  - Otherwise increment cur_index and go to LOAD.
  - cur_index never wraps within a sequence.
- FINISH: seq_done=1 for one cycle, busy=0, go to IDLE.
- FAIL: error=1, err_index=cur_index, busy=0, go to IDLE.
- Latency: go accepted to first m_start = 3 cycles when m_ready=1 (IDLE -> LOAD -> WAIT_READY -> ISSUE).
- m_start is never asserted while m_ready=0.
- Counters are sized to clog2(max(TIMEOUT, GAP_CYCLES)+1) bits and saturate; they never wrap.
- reset_n=0 in any state aborts immediately; no further m_start until a new go.

Optional Feature:
- Macro: I2C_SEQ_RETRY_EN.
- Defined:
  - A timeout in WAIT_READY or WAIT_DONE increments the retry counter and goes to GAP, then reissues the same cur_index via LOAD.
  - FAIL is entered only when a timeout occurs with the retry counter already at MAX_RETRY.
  - The retry counter clears on each successful entry.
  - Output retry_cnt (2 bits) is added.
- Undefined: the first timeout goes to FAIL; no retry_cnt port is present.

Decomposition:
- Shared package i2c_pkg:
  - State enum encoding.
  - DEV_ADDR default.
  - Table-entry type {sub[7:0], data[7:0]}.
- Sub-module i2c_init_rom: combinational lookup from index to {sub, data}. Default table:
  - 0: {0x20, 0x0F}
  - 1: {0x23, 0x30}
  - 2: {0x22, 0x08}
  - 3: {0x21, 0x00}

Test Plan:
- Normal sequence: master model with m_ready=1 raises m_done 20 cycles after m_start, go pulsed once -> exactly 4 one-cycle m_start, m_addr=0x68, (sub, data) = (20,0F), (23,30), (22,08), (21,00) in order; ≥16 idle cycles between m_done and the next m_start; one seq_done pulse; error=0.
- Duplicate go: go pulsed again during entry 2 -> ignored; still 4 m_start and one seq_done.
- Ready backpressure: m_ready=0 for 100 cycles after go, then 1 -> first m_start exactly 1 cycle after m_ready rises, never while m_ready=0.
- Timeout (feature off): m_done never rises on entry 1 -> FAIL exactly TIMEOUT cycles after that m_start; error=1, err_index=1, busy=0, no seq_done. A following go clears error.
- Reset mid-transfer: reset_n=0 for 1 cycle in WAIT_DONE of entry 2 -> all outputs at reset values next edge; no m_start until a new go, after which the table restarts at entry 0.
- Retry (I2C_SEQ_RETRY_EN): m_done suppressed on the first attempt of entry 1 only -> entry 1 reissued after GAP; sequence completes; error=0; retry_cnt reads 1 during the retry and 0 afterwards.
